// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y86_pkg
// Description : Y86-64 instruction, register and status encodings, plus the
//               decode-to-execute pipeline register layout and its nop value.
// Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] SAOK = 4'b1000;
    localparam logic [3:0] SHLT = 4'b0100;
    localparam logic [3:0] SADR = 4'b0010;
    localparam logic [3:0] SINS = 4'b0001;

    localparam logic [3:0] BUB_ICODE = INOP;
    localparam logic [3:0] BUB_IFUN  = 4'h0;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  stat;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
    } e_reg_t;

    localparam e_reg_t E_NOP = '{
        icode: BUB_ICODE, ifun: BUB_IFUN, stat: SAOK,
        valC: 64'd0, valA: 64'd0, valB: 64'd0,
        dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE
    };

endpackage : y86_pkg
`default_nettype wire

// File: rtl/decode_writeback_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_writeback_if
// Description : Pipeline bundle around decode: D register in, forward and
//               write-back sources in, E register and source IDs out.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_writeback_if #(
    parameter int DATA_W = 64
);
    logic [3:0]        D_icode, D_ifun, D_rA, D_rB, D_stat;
    logic [DATA_W-1:0] D_valC, D_valP;
    logic [3:0]        e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [DATA_W-1:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic              E_bubble;
    logic [3:0]        d_srcA, d_srcB;
    logic [3:0]        E_icode, E_ifun, E_stat;
    logic [DATA_W-1:0] E_valC, E_valA, E_valB;
    logic [3:0]        E_dstE, E_dstM, E_srcA, E_srcB;

    // Upstream pipeline / hazard-control side.
    modport master (
        output D_icode, D_ifun, D_rA, D_rB, D_stat, D_valC, D_valP,
        output e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
        output W_dstE, W_valE, W_dstM, W_valM, E_bubble,
        input  d_srcA, d_srcB,
        input  E_icode, E_ifun, E_stat, E_valC, E_valA, E_valB,
        input  E_dstE, E_dstM, E_srcA, E_srcB
    );

    // Decode stage side.
    modport slave (
        input  D_icode, D_ifun, D_rA, D_rB, D_stat, D_valC, D_valP,
        input  e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
        input  W_dstE, W_valE, W_dstM, W_valM, E_bubble,
        output d_srcA, d_srcB,
        output E_icode, E_ifun, E_stat, E_valC, E_valA, E_valB,
        output E_dstE, E_dstM, E_srcA, E_srcB
    );
endinterface : decode_writeback_if
`default_nettype wire

// File: rtl/y86_regfile.sv
`default_nettype none
// ============================================================================
// Module      : y86_regfile
// Description : 15x64 register file, two combinational reads, two writes
//               with the M port overriding the E port on the same register.
// Revision    : 1.0 - initial release
// ============================================================================
module y86_regfile
    import y86_pkg::*;
#(
    parameter int                 DATA_W     = 64,
    parameter logic [DATA_W-1:0]  STACK_INIT = 64'd1024
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [3:0]        i_rd_addr_a,
    output logic      [DATA_W-1:0] o_rd_data_a,
    input  wire logic [3:0]        i_rd_addr_b,
    output logic      [DATA_W-1:0] o_rd_data_b,
    input  wire logic [3:0]        i_wr_addr_e,
    input  wire logic [DATA_W-1:0] i_wr_data_e,
    input  wire logic [3:0]        i_wr_addr_m,
    input  wire logic [DATA_W-1:0] i_wr_data_m
);

    logic [DATA_W-1:0] r_regs [0:14];

    // Later nonblocking assignment wins, so the M write takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                r_regs[i] <= (i == int'(RSP)) ? STACK_INIT : '0;
            end
        end else begin
            if (i_wr_addr_e != RNONE) r_regs[i_wr_addr_e] <= i_wr_data_e;
            if (i_wr_addr_m != RNONE) r_regs[i_wr_addr_m] <= i_wr_data_m;
        end
    end

    assign o_rd_data_a = (i_rd_addr_a == RNONE) ? '0 : r_regs[i_rd_addr_a];
    assign o_rd_data_b = (i_rd_addr_b == RNONE) ? '0 : r_regs[i_rd_addr_b];

endmodule : y86_regfile
`default_nettype wire

// File: rtl/decode_writeback.sv
`default_nettype none
// ============================================================================
// Module      : decode_writeback
// Description : Y86-64 decode/write-back stage: operand decode, register file,
//               E/M/W forwarding and the E pipeline register with bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_writeback
    import y86_pkg::*;
#(
    parameter logic [63:0] STACK_INIT = 64'd1024,
    parameter int          DATA_W     = 64
) (
    input  wire logic         clk,
    input  wire logic         reset,
    decode_writeback_if.slave bus
);

    logic [3:0]        w_srcA, w_srcB, w_dstE, w_dstM;
    logic [DATA_W-1:0] w_rf_a, w_rf_b, w_valA, w_valB;
    e_reg_t            r_e;

    y86_regfile #(
        .DATA_W     (DATA_W),
        .STACK_INIT (STACK_INIT[DATA_W-1:0])
    ) u_regfile (
        .clk         (clk),
        .rst         (reset),
        .i_rd_addr_a (w_srcA),
        .o_rd_data_a (w_rf_a),
        .i_rd_addr_b (w_srcB),
        .o_rd_data_b (w_rf_b),
        .i_wr_addr_e (bus.W_dstE),
        .i_wr_data_e (bus.W_valE),
        .i_wr_addr_m (bus.W_dstM),
        .i_wr_data_m (bus.W_valM)
    );

    // Undefined icodes fall into the default and leave every ID at RNONE.
    always_comb begin
        w_srcA = RNONE;
        w_srcB = RNONE;
        w_dstE = RNONE;
        w_dstM = RNONE;
        case (bus.D_icode)
            IRRMOVQ: begin w_srcA = bus.D_rA; w_dstE = bus.D_rB; end
            IIRMOVQ: begin w_dstE = bus.D_rB; end
            IRMMOVQ: begin w_srcA = bus.D_rA; w_srcB = bus.D_rB; end
            IMRMOVQ: begin w_srcB = bus.D_rB; w_dstM = bus.D_rA; end
            IOPQ:    begin w_srcA = bus.D_rA; w_srcB = bus.D_rB; w_dstE = bus.D_rB; end
            ICALL:   begin w_srcB = RSP; w_dstE = RSP; end
            IRET:    begin w_srcA = RSP; w_srcB = RSP; w_dstE = RSP; end
            IPUSHQ:  begin w_srcA = bus.D_rA; w_srcB = RSP; w_dstE = RSP; end
            IPOPQ:   begin w_srcA = RSP; w_srcB = RSP; w_dstE = RSP; w_dstM = bus.D_rA; end
            default: ;
        endcase
    end

    // Youngest producer wins; the W entries also cover same-cycle regfile writes.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [3:0]        src,
        input logic [DATA_W-1:0] rf,
        input logic [3:0]        e_dstE, input logic [DATA_W-1:0] e_valE,
        input logic [3:0]        M_dstM, input logic [DATA_W-1:0] m_valM,
        input logic [3:0]        M_dstE, input logic [DATA_W-1:0] M_valE,
        input logic [3:0]        W_dstM, input logic [DATA_W-1:0] W_valM,
        input logic [3:0]        W_dstE, input logic [DATA_W-1:0] W_valE
    );
        if (src == RNONE)       return rf;
        else if (src == e_dstE) return e_valE;
        else if (src == M_dstM) return m_valM;
        else if (src == M_dstE) return M_valE;
        else if (src == W_dstM) return W_valM;
        else if (src == W_dstE) return W_valE;
        else                    return rf;
    endfunction

    always_comb begin
        w_valA = fwd(w_srcA, w_rf_a, bus.e_dstE, bus.e_valE, bus.M_dstM, bus.m_valM,
                     bus.M_dstE, bus.M_valE, bus.W_dstM, bus.W_valM, bus.W_dstE, bus.W_valE);
        if (bus.D_icode == ICALL || bus.D_icode == IJXX) w_valA = bus.D_valP;
        w_valB = fwd(w_srcB, w_rf_b, bus.e_dstE, bus.e_valE, bus.M_dstM, bus.m_valM,
                     bus.M_dstE, bus.M_valE, bus.W_dstM, bus.W_valM, bus.W_dstE, bus.W_valE);
    end

    always_ff @(posedge clk) begin
        if (reset || bus.E_bubble) begin
            r_e <= E_NOP;
        end else begin
            r_e.icode <= bus.D_icode;
            r_e.ifun  <= bus.D_ifun;
            r_e.stat  <= bus.D_stat;
            r_e.valC  <= bus.D_valC;
            r_e.valA  <= w_valA;
            r_e.valB  <= w_valB;
            r_e.dstE  <= w_dstE;
            r_e.dstM  <= w_dstM;
            r_e.srcA  <= w_srcA;
            r_e.srcB  <= w_srcB;
        end
    end

    assign bus.d_srcA  = w_srcA;
    assign bus.d_srcB  = w_srcB;
    assign bus.E_icode = r_e.icode;
    assign bus.E_ifun  = r_e.ifun;
    assign bus.E_stat  = r_e.stat;
    assign bus.E_valC  = r_e.valC;
    assign bus.E_valA  = r_e.valA;
    assign bus.E_valB  = r_e.valB;
    assign bus.E_dstE  = r_e.dstE;
    assign bus.E_dstM  = r_e.dstM;
    assign bus.E_srcA  = r_e.srcA;
    assign bus.E_srcB  = r_e.srcB;

endmodule : decode_writeback
`default_nettype wire

// File: tb/tb_decode_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_writeback
// Description : Directed-vector scoreboard bench for decode_writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_writeback;
    import y86_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_writeback_if #(.DATA_W(64)) dif ();

    decode_writeback #(
        .STACK_INIT (64'd1024),
        .DATA_W     (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    typedef struct {
        int     id;
        e_reg_t e;
    } exp_t;

    exp_t   q[$];
    exp_t   x;
    e_reg_t got;
    int     n_vec  = 0;
    int     n_miss = 0;

    task automatic idle_fwd();
        dif.e_dstE = RNONE; dif.e_valE = '0;
        dif.M_dstE = RNONE; dif.M_valE = '0;
        dif.M_dstM = RNONE; dif.m_valM = '0;
        dif.W_dstE = RNONE; dif.W_valE = '0;
        dif.W_dstM = RNONE; dif.W_valM = '0;
        dif.E_bubble = 1'b0;
    endtask

    task automatic set_d(input logic [3:0] ic, fn, ra, rb,
                         input logic [63:0] vc, vp, input logic [3:0] st);
        dif.D_icode = ic; dif.D_ifun = fn; dif.D_rA = ra; dif.D_rB = rb;
        dif.D_valC = vc; dif.D_valP = vp; dif.D_stat = st;
    endtask

    task automatic expect_e(input int id, input logic [3:0] ic, fn, st,
                            input logic [63:0] vc, va, vb,
                            input logic [3:0] de, dm, sa, sb);
        exp_t t;
        t.id = id;
        t.e  = '{icode: ic, ifun: fn, stat: st, valC: vc, valA: va, valB: vb,
                 dstE: de, dstM: dm, srcA: sa, srcB: sb};
        q.push_back(t);
    endtask

    task automatic expect_nop(input int id);
        expect_e(id, 4'h1, 4'h0, 4'b1000, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 4'hF, 4'hF);
    endtask

    task automatic check_src(input string name, input logic [3:0] g, w);
        n_vec++;
        if (g !== w) begin
            n_miss++;
            $display("FAIL %s got=%h want=%h", name, g, w);
        end
    endtask

    // Monitor: the E register presents a new value after every edge.
    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            x = q.pop_front();
            got = '{icode: dif.E_icode, ifun: dif.E_ifun, stat: dif.E_stat,
                    valC: dif.E_valC, valA: dif.E_valA, valB: dif.E_valB,
                    dstE: dif.E_dstE, dstM: dif.E_dstM, srcA: dif.E_srcA, srcB: dif.E_srcB};
            n_vec++;
            if (got !== x.e) begin
                n_miss++;
                $display("FAIL vec%0d E_reg got=%h want=%h", x.id, got, x.e);
            end
        end
    end

    initial begin
        reset = 1'b1;
        idle_fwd();
        set_d(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 4'b1000);

        // Reset held two cycles
        @(negedge clk); expect_nop(0);
        @(negedge clk); expect_nop(1);

        // pushq %rax: rsp read back as STACK_INIT
        @(negedge clk); reset = 1'b0; idle_fwd();
        set_d(4'hA, 4'h0, 4'h0, 4'hF, 64'd0, 64'd2, 4'b1000);
        #1 check_src("push_srcB", dif.d_srcB, 4'h4);
        expect_e(2, 4'hA, 4'h0, 4'b1000, 64'd0, 64'd0, 64'd1024, 4'h4, 4'hF, 4'h0, 4'h4);

        // OPq r3,r3 with same-cycle W write of r3
        @(negedge clk); idle_fwd(); dif.W_dstE = 4'h3; dif.W_valE = 64'h55;
        set_d(4'h6, 4'h0, 4'h3, 4'h3, 64'd0, 64'd2, 4'b1000);
        expect_e(3, 4'h6, 4'h0, 4'b1000, 64'd0, 64'h55, 64'h55, 4'h3, 4'hF, 4'h3, 4'h3);

        // Same read from the register file now
        @(negedge clk); idle_fwd();
        set_d(4'h6, 4'h1, 4'h3, 4'h3, 64'd0, 64'd2, 4'b1000);
        expect_e(4, 4'h6, 4'h1, 4'b1000, 64'd0, 64'h55, 64'h55, 4'h3, 4'hF, 4'h3, 4'h3);

        // Forward priority e > M > W on r2
        @(negedge clk); idle_fwd();
        dif.e_dstE = 4'h2; dif.e_valE = 64'h11;
        dif.M_dstE = 4'h2; dif.M_valE = 64'h22;
        dif.W_dstE = 4'h2; dif.W_valE = 64'h33;
        set_d(4'h6, 4'h0, 4'h2, 4'h1, 64'd0, 64'd2, 4'b1000);
        expect_e(5, 4'h6, 4'h0, 4'b1000, 64'd0, 64'h11, 64'd0, 4'h1, 4'hF, 4'h2, 4'h1);

        @(negedge clk); idle_fwd();
        dif.M_dstE = 4'h2; dif.M_valE = 64'h22;
        dif.W_dstE = 4'h2; dif.W_valE = 64'h33;
        expect_e(6, 4'h6, 4'h0, 4'b1000, 64'd0, 64'h22, 64'd0, 4'h1, 4'hF, 4'h2, 4'h1);

        @(negedge clk); idle_fwd();
        dif.W_dstE = 4'h2; dif.W_valE = 64'h33;
        expect_e(7, 4'h6, 4'h0, 4'b1000, 64'd0, 64'h33, 64'd0, 4'h1, 4'hF, 4'h2, 4'h1);

        @(negedge clk); idle_fwd();
        expect_e(8, 4'h6, 4'h0, 4'b1000, 64'd0, 64'h33, 64'd0, 4'h1, 4'hF, 4'h2, 4'h1);

        // Load forward into rmmovq r5,(r6)
        @(negedge clk); idle_fwd(); dif.M_dstM = 4'h5; dif.m_valM = 64'hABCD;
        set_d(4'h4, 4'h0, 4'h5, 4'h6, 64'h10, 64'd10, 4'b1000);
        #1 check_src("rm_srcA", dif.d_srcA, 4'h5);
        check_src("rm_srcB", dif.d_srcB, 4'h6);
        expect_e(9, 4'h4, 4'h0, 4'b1000, 64'h10, 64'hABCD, 64'd0, 4'hF, 4'hF, 4'h5, 4'h6);

        // call uses valP, ret reads rsp on both ports
        @(negedge clk); idle_fwd();
        set_d(4'h8, 4'h0, 4'hF, 4'hF, 64'h100, 64'h40, 4'b1000);
        expect_e(10, 4'h8, 4'h0, 4'b1000, 64'h100, 64'h40, 64'd1024, 4'h4, 4'hF, 4'hF, 4'h4);

        @(negedge clk); idle_fwd();
        set_d(4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'h41, 4'b1000);
        expect_e(11, 4'h9, 4'h0, 4'b1000, 64'd0, 64'd1024, 64'd1024, 4'h4, 4'hF, 4'h4, 4'h4);

        // Bubble over valid D, plus dual write to r6 (M value wins)
        @(negedge clk); idle_fwd(); dif.E_bubble = 1'b1;
        dif.W_dstE = 4'h6; dif.W_valE = 64'd1;
        dif.W_dstM = 4'h6; dif.W_valM = 64'd2;
        set_d(4'h6, 4'h0, 4'h3, 4'h3, 64'd0, 64'd2, 4'b1000);
        expect_nop(12);

        @(negedge clk); idle_fwd();
        set_d(4'h6, 4'h0, 4'h6, 4'h6, 64'd0, 64'd2, 4'b1000);
        expect_e(13, 4'h6, 4'h0, 4'b1000, 64'd0, 64'd2, 64'd2, 4'h6, 4'hF, 4'h6, 4'h6);

        // popq r7
        @(negedge clk); idle_fwd();
        set_d(4'hB, 4'h0, 4'h7, 4'hF, 64'd0, 64'd2, 4'b1000);
        expect_e(14, 4'hB, 4'h0, 4'b1000, 64'd0, 64'd1024, 64'd1024, 4'h4, 4'h7, 4'h4, 4'h4);

        // Invalid icode, INS status passes through
        @(negedge clk); idle_fwd();
        set_d(4'hC, 4'h2, 4'h3, 4'h3, 64'h77, 64'd2, 4'b0001);
        #1 check_src("inv_srcA", dif.d_srcA, 4'hF);
        expect_e(15, 4'hC, 4'h2, 4'b0001, 64'h77, 64'd0, 64'd0, 4'hF, 4'hF, 4'hF, 4'hF);

        // mrmovq 0x18(r3),r8
        @(negedge clk); idle_fwd();
        set_d(4'h5, 4'h0, 4'h8, 4'h3, 64'h18, 64'd10, 4'b1000);
        expect_e(16, 4'h5, 4'h0, 4'b1000, 64'h18, 64'd0, 64'h55, 4'hF, 4'h8, 4'hF, 4'h3);

        // jxx uses valP; r4 written to 0x500 here
        @(negedge clk); idle_fwd(); dif.W_dstE = 4'h4; dif.W_valE = 64'h500;
        set_d(4'h7, 4'h3, 4'hF, 4'hF, 64'h200, 64'h99, 4'b1000);
        expect_e(17, 4'h7, 4'h3, 4'b1000, 64'h200, 64'h99, 64'd0, 4'hF, 4'hF, 4'hF, 4'hF);

        // Mid-stream reset with a W write that must be discarded
        @(negedge clk); reset = 1'b1; idle_fwd(); dif.W_dstE = 4'h3; dif.W_valE = 64'h999;
        set_d(4'h6, 4'h0, 4'h3, 4'h3, 64'd0, 64'd2, 4'b1000);
        expect_nop(18);

        @(negedge clk); reset = 1'b0; idle_fwd();
        set_d(4'h4, 4'h0, 4'h3, 4'h4, 64'h8, 64'd10, 4'b1000);
        expect_e(19, 4'h4, 4'h0, 4'b1000, 64'h8, 64'd0, 64'd1024, 4'hF, 4'hF, 4'h3, 4'h4);

        // halt with HLT status
        @(negedge clk); idle_fwd();
        set_d(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 4'b0100);
        expect_e(20, 4'h0, 4'h0, 4'b0100, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 4'hF, 4'hF);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #2;
        n_vec++;
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_decode_writeback
`default_nettype wire

// File: doc/decode_writeback.md
Name: decode_writeback

Overview:
- Decode stage of the Y86-64 five-stage pipeline. Sits directly downstream of fetch and consumes the D_* pipeline register that fetch produces.
- Holds the 15-entry architectural register file. Writes it from the W stage and reads it for the decoded instruction.
- Resolves data hazards by forwarding from the E, M and W stages.
- Drives the E_* pipeline register consumed by execute, with bubble support for the hazard-control unit.

Parameters:
- STACK_INIT, 64'd1024: reset value of %rsp (reg 4); all other registers reset to 0.
- DATA_W, 64: datapath width. Fixed by the ISA; exists only for readability.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears register file and E register
- D_icode, D_ifun  in  4 each  instruction code/function from fetch
- D_rA, D_rB  in  4 each  register specifiers (4'hF = none)
- D_valC, D_valP  in  64 each  constant word, fall-through PC
- D_stat  in  4  status, one-hot: AOK 1000, HLT 0100, ADR 0010, INS 0001
- e_dstE, e_valE  in  4/64  execute-stage result forward
- M_dstE, M_valE  in  4/64  memory-stage ALU result forward
- M_dstM, m_valM  in  4/64  memory-stage load result forward
- W_dstE, W_valE, W_dstM, W_valM  in  4/64/4/64  write-back ports and forward sources
- E_bubble  in  1  inject nop into E register this edge
- d_srcA, d_srcB  out  4 each  combinational source IDs, for load/use detection
- E_icode, E_ifun, E_stat  out  4 each  registered
- E_valC, E_valA, E_valB  out  64 each  registered
- E_dstE, E_dstM, E_srcA, E_srcB  out  4 each  registered

Behaviour:
- Register IDs: RSP = 4, RNONE = 15. Register 15 never exists: reads return 0 and writes are dropped.
- srcA:
  - rA for cmovxx(2), rmmovq(4), OPq(6), pushq(A)
  - RSP for popq(B), ret(9)
  - otherwise RNONE
- srcB:
  - rB for OPq, rmmovq, mrmovq(5)
  - RSP for pushq, popq, call(8), ret
  - otherwise RNONE
- dstE:
  - rB for cmovxx, irmovq(3), OPq
  - RSP for pushq, popq, call, ret
  - otherwise RNONE
- dstM: rA for mrmovq, popq; otherwise RNONE.
- d_valA:
  - D_valP if icode is call or jxx(7).
  - Otherwise first match in this priority order:
    1. srcA==e_dstE → e_valE
    2. srcA==M_dstM → m_valM
    3. srcA==M_dstE → M_valE
    4. srcA==W_dstM → W_valM
    5. srcA==W_dstE → W_valE
    6. else regfile[srcA]
  - Matches are only valid when srcA != RNONE.
- d_valB: same chain on srcB, with no valP case.
- Register file:
  - Reads are combinational.
  - Writes happen on posedge: W_dstE←W_valE and W_dstM←W_valM.
  - If W_dstE==W_dstM (≠RNONE), W_valM wins.
  - A same-cycle read of a register being written returns the new value via the W forward, not the stale array value.
- E register, on posedge, in priority order:
  1. reset
  2. E_bubble
  3. load
- Bubble/reset value of the E register:
  - icode=1 (nop), ifun=0
  - valC/valA/valB=0
  - dstE/dstM/srcA/srcB=4'hF
  - stat=AOK
- Load: E_* ← {D_icode, D_ifun, D_stat, D_valC, d_valA, d_valB, dstE, dstM, srcA, srcB}.
- Latency: one cycle from D_* to E_*. There is no stall input; decode stalls are handled by holding D upstream.
- Reset mid-stream:
  - Register file returns to reset values in the same edge; %rsp = STACK_INIT.
  - Any W write presented in the reset cycle is discarded.
- Invalid D_icode (> B): all src/dst = RNONE; stat is passed through unchanged from D_stat.
- No $finish or $display in this block; status is only propagated.

Decomposition:
- Package y86_pkg holds:
  - icode constants: IHALT…IPOPQ
  - RSP, RNONE
  - stat codes: SAOK, SHLT, SADR, SINS
  - nop bubble constants
- Sub-module y86_regfile:
  - 15x64 array
  - 2 combinational read ports, 2 write ports with M-over-E priority
  - synchronous reset using STACK_INIT

Test Plan:
- Reset: hold reset 2 cycles → E_icode=1, E_dstE=F, E_stat=1000. Decode pushq %rax (A0 0F) → d_valB=1024 (rsp).
- Write-back: W_dstE=3, W_valE=0x55 with D = OPq rA=3 rB=3 in the same cycle → E_valA=E_valB=0x55. Next cycle the regfile read also returns 0x55.
- Forward priority: e_dstE=2/0x11, M_dstE=2/0x22, W_dstE=2/0x33, srcA=2 → E_valA=0x11. Drop e → 0x22. Drop M → 0x33.
- Load forward: M_dstM=5, m_valM=0xABCD, D = rmmovq rA=5 → E_valA=0xABCD. d_srcA=5 visible combinationally.
- Call/ret: D = call, D_valP=0x40 → E_valA=0x40, E_dstE=4, E_srcA=F. D = ret → E_srcA=E_srcB=4.
- Bubble/conflict: E_bubble=1 with valid D → E_icode=1, E_dstE=F. W_dstE=W_dstM=6 with values 1 and 2 → reg6=2.
